noc_tx_arbiter: RTL and testbench

//   Shares the single outbound NoC byte link (noc_from_dev_ctl/noc_from_dev_data) among N_SRC packet

---
 rtl/noc_tx_arbiter_if.sv | 30 +++
 rtl/noc_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_noc_tx_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/noc_tx_arbiter_if.sv
// Bundle between the NoC packet sources and the outbound link arbiter.
// Sources sit on the master side; the arbiter uses the slave side.
interface noc_tx_arbiter_if #(
  parameter int unsigned N_SRC = 3
);
  localparam int unsigned IDX_W = $clog2(N_SRC);

  logic [N_SRC-1:0]   req;
  logic [N_SRC-1:0]   src_ctl;
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_valid;
  logic [N_SRC-1:0]   src_last;
  logic [N_SRC-1:0]   gnt;
  logic [N_SRC-1:0]   accept;
  logic               noc_from_dev_ctl;
  logic [7:0]         noc_from_dev_data;
  logic               busy;
  logic               err_timeout;
  logic [IDX_W-1:0]   err_src;

  modport master (
    output req, src_ctl, src_data, src_valid, src_last,
    input  gnt, accept, noc_from_dev_ctl, noc_from_dev_data, busy, err_timeout, err_src
  );

  modport slave (
    input  req, src_ctl, src_data, src_valid, src_last,
    output gnt, accept, noc_from_dev_ctl, noc_from_dev_data, busy, err_timeout, err_src
  );
endinterface

// File: rtl/noc_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the outbound NoC byte link among N_SRC sources,
// with NOP fill on idle cycles and a stall watchdog that aborts a silent granted source.
module noc_tx_arbiter #(
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned MAX_GAP = 16
) (
  input  logic              clk,
  input  logic              rst,
  noc_tx_arbiter_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(N_SRC);
  localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  logic [0:0]       r_state,       w_state_nxt;
  logic [N_SRC-1:0] r_gnt,         w_gnt_nxt;
  logic [IDX_W-1:0] r_gidx,        w_gidx_nxt;
  logic [IDX_W-1:0] r_rr_ptr,      w_rr_ptr_nxt;
  logic [GAP_W-1:0] r_gap_cnt,     w_gap_cnt_nxt;
  logic             r_ctl,         w_ctl_nxt;
  logic [7:0]       r_data,        w_data_nxt;
  logic             r_err_timeout, w_err_timeout_nxt;
  logic [IDX_W-1:0] r_err_src,     w_err_src_nxt;

  logic [N_SRC-1:0] w_rot;
  logic             w_found;
  logic [IDX_W-1:0] w_ofs;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_g_inc;
  logic             w_g_valid;
  logic             w_g_last;
  logic             w_g_ctl;
  logic [7:0]       w_g_data;

  // Rotate requests so bit 0 is the current round-robin head
  assign w_rot = N_SRC'({bus.req, bus.req} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_ofs   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_ofs   = IDX_W'(k);
      end
    end
  end

  assign w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
  assign w_pick = (w_sum >= (IDX_W+1)'(N_SRC)) ? IDX_W'(w_sum - (IDX_W+1)'(N_SRC)) : IDX_W'(w_sum);
  assign w_g_inc = (r_gidx == IDX_W'(N_SRC - 1)) ? '0 : r_gidx + 1'b1;

  // Mux out the granted source's byte lane
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_ctl   = 1'b0;
    w_g_data  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_g_valid = bus.src_valid[i];
        w_g_last  = bus.src_last[i];
        w_g_ctl   = bus.src_ctl[i];
        w_g_data  = bus.src_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_nxt         = r_gnt;
    w_gidx_nxt        = r_gidx;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_err_src_nxt     = r_err_src;
    w_ctl_nxt         = 1'b1;
    w_data_nxt        = 8'h00;
    w_err_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt     = N_SRC'(1) << w_pick;
          w_gidx_nxt    = w_pick;
          w_gap_cnt_nxt = '0;
          w_state_nxt   = S_XFER;
        end
      end
      default: begin
        if (w_g_valid) begin
          w_ctl_nxt     = w_g_ctl;
          w_data_nxt    = w_g_data;
          w_gap_cnt_nxt = '0;
          if (w_g_last) begin
            w_gnt_nxt    = '0;
            w_rr_ptr_nxt = w_g_inc;
            w_state_nxt  = S_IDLE;
          end
        end else if (r_gap_cnt == GAP_W'(MAX_GAP - 1)) begin
          // Source went silent too long: drop it, the partial packet stays truncated
          w_err_timeout_nxt = 1'b1;
          w_err_src_nxt     = r_gidx;
          w_gnt_nxt         = '0;
          w_gap_cnt_nxt     = '0;
          w_rr_ptr_nxt      = w_g_inc;
          w_state_nxt       = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_gidx        <= '0;
      r_rr_ptr      <= '0;
      r_gap_cnt     <= '0;
      r_ctl         <= 1'b1;
      r_data        <= 8'h00;
      r_err_timeout <= 1'b0;
      r_err_src     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_gidx        <= w_gidx_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_ctl         <= w_ctl_nxt;
      r_data        <= w_data_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_err_src     <= w_err_src_nxt;
    end
  end

  assign bus.gnt               = r_gnt;
  assign bus.accept            = r_gnt & bus.src_valid & {N_SRC{r_state == S_XFER}};
  assign bus.noc_from_dev_ctl  = r_ctl;
  assign bus.noc_from_dev_data = r_data;
  assign bus.busy              = (r_state != S_IDLE);
  assign bus.err_timeout       = r_err_timeout;
  assign bus.err_src           = r_err_src;

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Directed bench for noc_tx_arbiter: reset, single source, round-robin, stall abort,
// sub-limit gap and mid-packet reset, all against hand-computed expectations.
module tb_noc_tx_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  noc_tx_arbiter_if #(.N_SRC(3)) bus ();

  noc_tx_arbiter #(.N_SRC(3), .MAX_GAP(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input bit c, input logic [7:0] d, input bit l);
    bus.src_valid[i]     = v;
    bus.src_ctl[i]       = c;
    bus.src_data[8*i +: 8] = d;
    bus.src_last[i]      = l;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_link(input string tag, input logic c, input logic [7:0] d);
    check({tag, "_ctl"},  32'(bus.noc_from_dev_ctl),  32'(c));
    check({tag, "_data"}, 32'(bus.noc_from_dev_data), 32'(d));
  endtask

  // Two-byte packet from granted source g, every source presenting bytes to prove isolation
  task automatic pkt2(input int g);
    logic [2:0] oh;
    oh = 3'(1 << g);
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
    #1 check("rr_acc0", 32'(bus.accept), 32'(oh));
    cyc();
    check_link("rr_b0", 1'b1, 8'(8'h10 + g));
    check("rr_gnt_mid", 32'(bus.gnt), 32'(oh));
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 1'b0, 8'(8'h20 + i), 1'b1);
    #1 check("rr_acc1", 32'(bus.accept), 32'(oh));
    cyc();
    check_link("rr_b1", 1'b0, 8'(8'h20 + g));
    check("rr_gnt_end", 32'(bus.gnt), 32'd0);
    check("rr_acc_idle", 32'(bus.accept), 32'd0);
    idle_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] sb [4];
    int order [4];
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.req = 3'b111;
    idle_all();

    // Reset held with all requests asserted
    repeat (2) begin
      cyc();
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check_link("rst_link", 1'b1, 8'h00);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.err_timeout), 32'd0);
    end
    rst = 1'b1;
    #1 check("rel_gnt", 32'(bus.gnt), 32'd0);
    cyc();
    check("rel_first_gnt", 32'(bus.gnt), 32'b001);
    check("rel_busy", 32'(bus.busy), 32'd1);
    bus.req = 3'b000;
    drive(0, 1'b1, 1'b1, 8'hAA, 1'b1);
    #1 check("sb_acc", 32'(bus.accept), 32'b001);
    cyc();
    check_link("sb_link", 1'b1, 8'hAA);
    check("sb_busy", 32'(bus.busy), 32'd0);
    idle_all();
    cyc();
    check_link("sb_nop", 1'b1, 8'h00);

    // Single source, four-byte packet
    sb[0] = 8'hC4; sb[1] = 8'h12; sb[2] = 8'h34; sb[3] = 8'h05;
    bus.req = 3'b010;
    cyc();
    check("ss_gnt", 32'(bus.gnt), 32'b010);
    check_link("ss_arb_nop", 1'b1, 8'h00);
    bus.req = 3'b000;
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, (b == 0), sb[b], (b == 3));
      #1 check("ss_acc", 32'(bus.accept), 32'b010);
      cyc();
      check_link("ss_byte", (b == 0), sb[b]);
    end
    check("ss_gnt_end", 32'(bus.gnt), 32'd0);
    idle_all();
    cyc();
    check_link("ss_nop", 1'b1, 8'h00);

    // Round-robin with all requests held; pointer now 2
    bus.req = 3'b111;
    order[0] = 2; order[1] = 0; order[2] = 1; order[3] = 2;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rr_gnt", 32'(bus.gnt), 32'(1 << order[k]));
      check_link("rr_nop", 1'b1, 8'h00);
      pkt2(order[k]);
      if (k == 3) bus.req = 3'b000;
    end
    cyc();
    check("rr_quiet", 32'(bus.gnt), 32'd0);

    // Stall watchdog on source 2; pointer now 0
    bus.req = 3'b100;
    cyc();
    check("st_gnt", 32'(bus.gnt), 32'b100);
    drive(2, 1'b1, 1'b1, 8'h5A, 1'b0);
    cyc();
    check_link("st_b0", 1'b1, 8'h5A);
    drive(2, 1'b0, 1'b0, 8'h00, 1'b0);
    bus.req = 3'b101;
    for (int s = 1; s <= 15; s++) begin
      cyc();
      check("st_err_low", 32'(bus.err_timeout), 32'd0);
      check("st_gnt_held", 32'(bus.gnt), 32'b100);
      check_link("st_nop", 1'b1, 8'h00);
    end
    cyc();
    check("st_err_pulse", 32'(bus.err_timeout), 32'd1);
    check("st_err_src", 32'(bus.err_src), 32'd2);
    check("st_gnt_drop", 32'(bus.gnt), 32'd0);
    check("st_busy", 32'(bus.busy), 32'd0);
    cyc();
    check("st_err_clr", 32'(bus.err_timeout), 32'd0);
    check("st_err_src_hold", 32'(bus.err_src), 32'd2);
    check("st_next_gnt", 32'(bus.gnt), 32'b001);
    bus.req = 3'b000;
    drive(0, 1'b1, 1'b1, 8'h77, 1'b1);
    cyc();
    check_link("st_s0", 1'b1, 8'h77);
    idle_all();

    // Gap of 15 stall cycles stays below the limit; pointer now 1
    bus.req = 3'b010;
    cyc();
    check("gp_gnt", 32'(bus.gnt), 32'b010);
    bus.req = 3'b000;
    drive(1, 1'b1, 1'b1, 8'hC1, 1'b0);
    cyc();
    check_link("gp_b0", 1'b1, 8'hC1);
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < 15; s++) begin
      cyc();
      check_link("gp_nop", 1'b1, 8'h00);
      check("gp_err", 32'(bus.err_timeout), 32'd0);
    end
    check("gp_gnt_held", 32'(bus.gnt), 32'b010);
    drive(1, 1'b1, 1'b0, 8'hE2, 1'b1);
    #1 check("gp_acc", 32'(bus.accept), 32'b010);
    cyc();
    check_link("gp_b1", 1'b0, 8'hE2);
    check("gp_err_end", 32'(bus.err_timeout), 32'd0);
    check("gp_gnt_end", 32'(bus.gnt), 32'd0);
    idle_all();

    // Reset mid-packet; pointer now 2, so a post-reset grant of 0 on req=111 shows pointer cleared
    bus.req = 3'b001;
    cyc();
    check("mr_gnt", 32'(bus.gnt), 32'b001);
    drive(0, 1'b1, 1'b1, 8'hB0, 1'b0);
    cyc();
    check_link("mr_b0", 1'b1, 8'hB0);
    drive(0, 1'b1, 1'b0, 8'hB1, 1'b0);
    rst = 1'b0;
    cyc();
    check("mr_gnt_rst", 32'(bus.gnt), 32'd0);
    check_link("mr_nop", 1'b1, 8'h00);
    check("mr_acc", 32'(bus.accept), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    idle_all();
    bus.req = 3'b111;
    cyc();
    check("mr_ptr_reset", 32'(bus.gnt), 32'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
